// File: rtl/fc1_ifm_streamer.sv
// Transmit side of the FC1 input-feature-map link: copies one flattened IFM from the
// upstream output memory into FC1's IFM buffer, then runs the start/end handshake.
module fc1_ifm_streamer #(
  parameter int DATA_WIDTH = 32,
  parameter int IFM_DEPTH  = 120,
  parameter int ADDR_W     = $clog2(IFM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_from_previous,
  output logic                  end_to_previous,
  output logic                  src_enable_read,
  output logic [ADDR_W-1:0]     src_address,
  input  logic [DATA_WIDTH-1:0] src_data,
  output logic [DATA_WIDTH-1:0] data_out_to_next,
  output logic [ADDR_W-1:0]     ifm_address_next,
  output logic                  ifm_enable_write_next,
  output logic                  start_to_next,
  input  logic                  end_from_next,
  output logic                  busy
);

  typedef enum logic [2:0] {
    IDLE,
    STREAM,
    FLUSH,
    START,
    WAIT_END
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IFM_DEPTH - 1);

  state_t                  state;
  logic [ADDR_W-1:0]       rd_cnt;
  logic                    vld_p0;
  logic                    start_pulse;
  logic                    vld_p1;
  logic [ADDR_W-1:0]       addr_p1;
  logic [DATA_WIDTH-1:0]   data_hold_p1;

  // Stage p0: read sequencing and handshake control
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      rd_cnt      <= '0;
      vld_p0      <= 1'b0;
      start_pulse <= 1'b0;
    end else begin
      vld_p0      <= 1'b0;
      start_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (start_from_previous) begin
            state  <= STREAM;
            rd_cnt <= '0;
            vld_p0 <= 1'b1;
          end
        end
        STREAM: begin
          if (rd_cnt == LAST_ADDR) begin
            state <= FLUSH;
          end else begin
            rd_cnt <= rd_cnt + 1'b1;
            vld_p0 <= 1'b1;
          end
        end
        FLUSH: begin
          state       <= START;
          start_pulse <= 1'b1;
        end
        START: begin
          state <= WAIT_END;
        end
        WAIT_END: begin
          if (end_from_next) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Stage p1: write strobe/address follow the read by one cycle; data arrives from the memory then
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1       <= 1'b0;
      addr_p1      <= '0;
      data_hold_p1 <= '0;
    end else begin
      vld_p1       <= vld_p0;
      data_hold_p1 <= data_out_to_next;
      if (vld_p0) begin
        addr_p1 <= rd_cnt;
      end
    end
  end

  assign src_enable_read       = vld_p0;
  assign src_address           = rd_cnt;
  assign ifm_enable_write_next = vld_p1;
  assign ifm_address_next      = addr_p1;
  assign data_out_to_next      = vld_p1 ? src_data : data_hold_p1;
  assign start_to_next         = start_pulse;
  // An end already present on the first WAIT_END cycle is answered in that same cycle.
  assign end_to_previous       = (state == WAIT_END) && end_from_next;
  assign busy                  = (state != IDLE);

  a_cnt_range : assert property (@(posedge clk) disable iff (!reset) rd_cnt <= LAST_ADDR);
  a_no_write_at_start : assert property (@(posedge clk) disable iff (!reset)
    start_to_next |-> !ifm_enable_write_next);

endmodule

// File: tb/tb_fc1_ifm_streamer.sv
// Randomized self-checking bench for fc1_ifm_streamer against a cycle-level transfer model.
module tb_fc1_ifm_streamer;
  localparam int DW    = 32;
  localparam int DEPTH = 120;
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = 32 + AW + DW;
  localparam int ZW    = 5 + 2 * AW + DW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start_from_previous = 1'b0;
  logic          end_from_next = 1'b0;
  logic [DW-1:0] src_data = '0;
  logic          end_to_previous;
  logic          src_enable_read;
  logic [AW-1:0] src_address;
  logic [DW-1:0] data_out_to_next;
  logic [AW-1:0] ifm_address_next;
  logic          ifm_enable_write_next;
  logic          start_to_next;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t_start  = 0;

  logic [DW-1:0] mem [DEPTH];
  int            wr_cyc  [$];
  logic [AW-1:0] wr_addr [$];
  logic [DW-1:0] wr_data [$];
  int            st_cyc  [$];
  int            en_cyc  [$];

  fc1_ifm_streamer dut (
    .clk                   (clk),
    .reset                 (reset),
    .start_from_previous   (start_from_previous),
    .end_to_previous       (end_to_previous),
    .src_enable_read       (src_enable_read),
    .src_address           (src_address),
    .src_data              (src_data),
    .data_out_to_next      (data_out_to_next),
    .ifm_address_next      (ifm_address_next),
    .ifm_enable_write_next (ifm_enable_write_next),
    .start_to_next         (start_to_next),
    .end_from_next         (end_from_next),
    .busy                  (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Upstream memory with one cycle of read latency; noise on the bus while in reset.
  always @(posedge clk) begin
    if (!reset) src_data <= $urandom();
    else if (src_enable_read) src_data <= mem[src_address];
  end

  always @(negedge clk) begin
    if (reset) begin
      if (ifm_enable_write_next) begin
        wr_cyc.push_back(cyc - t_start);
        wr_addr.push_back(ifm_address_next);
        wr_data.push_back(data_out_to_next);
      end
      if (start_to_next) st_cyc.push_back(cyc - t_start);
      if (end_to_previous) en_cyc.push_back(cyc - t_start);
    end
  end

  // Reference: word k lands in FC1 two cycles after the start request plus k.
  function automatic logic [PW-1:0] model_write(int k);
    return {32'(2 + k), AW'(k), mem[k]};
  endfunction

  function automatic logic [PW-1:0] got_write(int i);
    if (i >= wr_cyc.size()) return '1;
    return {32'(wr_cyc[i]), wr_addr[i], wr_data[i]};
  endfunction

  function automatic logic [ZW-1:0] all_outputs();
    return {end_to_previous, src_enable_read, src_address, data_out_to_next,
            ifm_address_next, ifm_enable_write_next, start_to_next, busy};
  endfunction

  task automatic fill_mem(bit ramp);
    for (int k = 0; k < DEPTH; k++) mem[k] = ramp ? DW'(k + 100) : $urandom();
  endtask

  task automatic kick();
    @(posedge clk); #1;
    start_from_previous = 1'b1;
    t_start = cyc;
    wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
    st_cyc.delete(); en_cyc.delete();
    @(posedge clk); #1;
    start_from_previous = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      start_from_previous = 1'($urandom());
      end_from_next       = 1'($urandom());
      @(negedge clk);
      n_checks++;
      if (all_outputs() !== '0) begin
        n_fail++;
        $display("FAIL reset_hold got %0h expected 0", all_outputs());
      end
    end
    start_from_previous = 1'b0;
    end_from_next       = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (all_outputs() !== '0) begin
        n_fail++;
        $display("FAIL reset_release got %0h expected 0", all_outputs());
      end
    end
  endtask

  task automatic test_nominal();
    fill_mem(1'b1);
    end_from_next = 1'b0;
    kick();
    for (int n = 2; n <= 135; n++) begin
      @(posedge clk); #1;
      end_from_next = (n == 125);
    end
    n_checks++;
    if (wr_cyc.size() !== DEPTH) begin
      n_fail++;
      $display("FAIL nominal_count got %0d expected %0d", wr_cyc.size(), DEPTH);
    end
    for (int k = 0; k < DEPTH; k++) begin
      n_checks++;
      if (got_write(k) !== model_write(k)) begin
        n_fail++;
        $display("FAIL nominal_word%0d got %0h expected %0h", k, got_write(k), model_write(k));
      end
    end
    n_checks++;
    if (st_cyc.size() !== 1 || st_cyc[0] !== DEPTH + 2) begin
      n_fail++;
      $display("FAIL nominal_start got %0d pulses first %0d expected 1 at %0d",
               st_cyc.size(), (st_cyc.size() > 0) ? st_cyc[0] : -1, DEPTH + 2);
    end
    n_checks++;
    if (en_cyc.size() !== 1 || en_cyc[0] !== 125) begin
      n_fail++;
      $display("FAIL nominal_end got %0d pulses first %0d expected 1 at 125",
               en_cyc.size(), (en_cyc.size() > 0) ? en_cyc[0] : -1);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL nominal_idle got busy=%0b expected 0", busy);
    end
  endtask

  task automatic test_handshake();
    int idle_cycles;
    fill_mem(1'b0);
    end_from_next = 1'b0;
    idle_cycles = 0;
    kick();
    for (int n = 2; n <= 176; n++) begin
      @(posedge clk); #1;
      end_from_next = (n >= 173 && n <= 175);
      if (n <= 172 && busy !== 1'b1) idle_cycles++;
    end
    n_checks++;
    if (idle_cycles !== 0) begin
      n_fail++;
      $display("FAIL handshake_busy got %0d idle cycles expected 0", idle_cycles);
    end
    n_checks++;
    if (en_cyc.size() !== 1 || en_cyc[0] !== 173) begin
      n_fail++;
      $display("FAIL handshake_end got %0d pulses first %0d expected 1 at 173",
               en_cyc.size(), (en_cyc.size() > 0) ? en_cyc[0] : -1);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL handshake_idle got busy=%0b expected 0", busy);
    end
    // Second image from the same memory contents.
    kick();
    for (int n = 2; n <= 130; n++) begin
      @(posedge clk); #1;
      end_from_next = (n >= 124 && n <= 126);
    end
    n_checks++;
    if (wr_cyc.size() !== DEPTH) begin
      n_fail++;
      $display("FAIL second_count got %0d expected %0d", wr_cyc.size(), DEPTH);
    end
    for (int k = 0; k < DEPTH; k++) begin
      n_checks++;
      if (got_write(k) !== model_write(k)) begin
        n_fail++;
        $display("FAIL second_word%0d got %0h expected %0h", k, got_write(k), model_write(k));
      end
    end
    n_checks++;
    if (en_cyc.size() !== 1 || en_cyc[0] !== 124) begin
      n_fail++;
      $display("FAIL second_end got %0d pulses first %0d expected 1 at 124",
               en_cyc.size(), (en_cyc.size() > 0) ? en_cyc[0] : -1);
    end
  endtask

  task automatic test_ignore();
    fill_mem(1'b0);
    end_from_next = 1'b0;
    kick();
    for (int n = 2; n <= 160; n++) begin
      @(posedge clk); #1;
      start_from_previous = (n == 60) || (n == 130);
      end_from_next       = (n == 70) || (n == 121) || (n == 122) || (n == 140);
    end
    start_from_previous = 1'b0;
    end_from_next       = 1'b0;
    n_checks++;
    if (wr_cyc.size() !== DEPTH) begin
      n_fail++;
      $display("FAIL ignore_count got %0d expected %0d", wr_cyc.size(), DEPTH);
    end
    for (int k = 0; k < DEPTH; k++) begin
      n_checks++;
      if (got_write(k) !== model_write(k)) begin
        n_fail++;
        $display("FAIL ignore_word%0d got %0h expected %0h", k, got_write(k), model_write(k));
      end
    end
    n_checks++;
    if (st_cyc.size() !== 1 || st_cyc[0] !== DEPTH + 2) begin
      n_fail++;
      $display("FAIL ignore_start got %0d pulses first %0d expected 1 at %0d",
               st_cyc.size(), (st_cyc.size() > 0) ? st_cyc[0] : -1, DEPTH + 2);
    end
    n_checks++;
    if (en_cyc.size() !== 1 || en_cyc[0] !== 140) begin
      n_fail++;
      $display("FAIL ignore_end got %0d pulses first %0d expected 1 at 140",
               en_cyc.size(), (en_cyc.size() > 0) ? en_cyc[0] : -1);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_idle got busy=%0b expected 0", busy);
    end
  endtask

  task automatic test_abort();
    logic [AW+DW:0] bus_exp;
    fill_mem(1'b0);
    end_from_next = 1'b0;
    kick();
    for (int n = 2; n <= 59; n++) begin
      @(posedge clk); #1;
    end
    bus_exp = {1'b1, AW'(57), mem[57]};
    n_checks++;
    if ({ifm_enable_write_next, ifm_address_next, data_out_to_next} !== bus_exp) begin
      n_fail++;
      $display("FAIL abort_write57 got %0h expected %0h",
               {ifm_enable_write_next, ifm_address_next, data_out_to_next}, bus_exp);
    end
    #1 reset = 1'b0;
    #1;
    n_checks++;
    if (all_outputs() !== '0) begin
      n_fail++;
      $display("FAIL abort_async got %0h expected 0", all_outputs());
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (all_outputs() !== '0) begin
      n_fail++;
      $display("FAIL abort_held got %0h expected 0", all_outputs());
    end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (wr_cyc.size() !== 57 || busy !== 1'b0 || st_cyc.size() !== 0 || en_cyc.size() !== 0) begin
      n_fail++;
      $display("FAIL abort_quiet got writes=%0d busy=%0b starts=%0d ends=%0d expected 57 0 0 0",
               wr_cyc.size(), busy, st_cyc.size(), en_cyc.size());
    end
    kick();
    for (int n = 2; n <= 130; n++) begin
      @(posedge clk); #1;
      end_from_next = (n == 126);
    end
    n_checks++;
    if (wr_cyc.size() !== DEPTH) begin
      n_fail++;
      $display("FAIL restart_count got %0d expected %0d", wr_cyc.size(), DEPTH);
    end
    for (int k = 0; k < DEPTH; k++) begin
      n_checks++;
      if (got_write(k) !== model_write(k)) begin
        n_fail++;
        $display("FAIL restart_word%0d got %0h expected %0h", k, got_write(k), model_write(k));
      end
    end
    n_checks++;
    if (en_cyc.size() !== 1 || en_cyc[0] !== 126) begin
      n_fail++;
      $display("FAIL restart_end got %0d pulses first %0d expected 1 at 126",
               en_cyc.size(), (en_cyc.size() > 0) ? en_cyc[0] : -1);
    end
  endtask

  task automatic test_early_end();
    logic busy_124;
    fill_mem(1'b0);
    end_from_next = 1'b1;
    busy_124 = 1'b1;
    kick();
    for (int n = 2; n <= 130; n++) begin
      @(posedge clk); #1;
      end_from_next = (n <= 127);
      if (n == 124) busy_124 = busy;
    end
    end_from_next = 1'b0;
    n_checks++;
    if (st_cyc.size() !== 1 || st_cyc[0] !== DEPTH + 2) begin
      n_fail++;
      $display("FAIL early_start got %0d pulses first %0d expected 1 at %0d",
               st_cyc.size(), (st_cyc.size() > 0) ? st_cyc[0] : -1, DEPTH + 2);
    end
    n_checks++;
    if (en_cyc.size() !== 1 || en_cyc[0] !== DEPTH + 3) begin
      n_fail++;
      $display("FAIL early_end got %0d pulses first %0d expected 1 at %0d",
               en_cyc.size(), (en_cyc.size() > 0) ? en_cyc[0] : -1, DEPTH + 3);
    end
    n_checks++;
    if (busy_124 !== 1'b0) begin
      n_fail++;
      $display("FAIL early_idle got busy=%0b expected 0", busy_124);
    end
    n_checks++;
    if (wr_cyc.size() !== DEPTH || got_write(DEPTH - 1) !== model_write(DEPTH - 1)) begin
      n_fail++;
      $display("FAIL early_writes got %0d last %0h expected %0d last %0h",
               wr_cyc.size(), got_write(DEPTH - 1), DEPTH, model_write(DEPTH - 1));
    end
  endtask

  initial begin
    for (int k = 0; k < DEPTH; k++) mem[k] = '0;
    test_reset();
    test_nominal();
    test_handshake();
    test_ignore();
    test_abort();
    test_early_end();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
